lcd_seq_ctrl: RTL

- Sequencing controller for the LCD datapath (`LCD_dp`). It drives the datapath's mux selects (`init_sel`, `data_sel`, `DB_sel`, `index`) and coherent copies of `state`/`statelocal`.
- It also generates the HD44780-style bus strobes `LCD_E`, `LCD_RS` and `LCD_RW`.
- After reset it runs power-up wait plus a 4-command init, then writes one display frame per `refresh` request. Frames are 1 address command plus 2 or 4 characters.
- Sits between the calculator top-level FSM (source of `state`/`statelocal`) and `LCD_dp`, whose `DB_out` goes straight to the LCD pins.

---
 rtl/lcd_seq_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/lcd_seq_ctrl.sv
// HD44780 write sequencer: power-up wait, 4-command init, then one address+2/4-char frame per refresh.
// Latency: a refresh seen in IDLE enters SETUP the next cycle; otherwise it is held pending (1-deep) until IDLE.
module lcd_seq_ctrl #(
    parameter int T_PWR = 750000,
    parameter int T_EH  = 12,
    parameter int T_CMD = 2000,
    parameter int T_CLR = 82000,
    parameter int CW    = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refresh,
    input  logic [1:0] state,
    input  logic [2:0] statelocal,
    output logic [1:0] state_o,
    output logic [2:0] statelocal_o,
    output logic [1:0] init_sel,
    output logic       data_sel,
    output logic       DB_sel,
    output logic [1:0] index,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       ready
);

    typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_ADDR, S_CHAR} seq_state_t;
    typedef enum logic [1:0] {P_SETUP, P_EHI, P_WAIT} phase_t;

    seq_state_t     st_q, st_d;
    phase_t         ph_q, ph_d;
    logic [CW-1:0]  tmr_q, tmr_d;
    logic           pend_q, pend_d;
    logic [1:0]     state_q, state_d;
    logic [2:0]     sl_q, sl_d;
    logic [1:0]     isel_q, isel_d;
    logic           ds_q, ds_d;
    logic           db_q, db_d;
    logic [1:0]     idx_q, idx_d;
    logic           rs_q, rs_d;
    logic [1:0]     last_q, last_d;
    logic           wr_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= S_PWR;
            ph_q    <= P_SETUP;
            tmr_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= '0;
            sl_q    <= '0;
            isel_q  <= '0;
            ds_q    <= 1'b0;
            db_q    <= 1'b0;
            idx_q   <= '0;
            rs_q    <= 1'b0;
            last_q  <= '0;
        end else begin
            st_q    <= st_d;
            ph_q    <= ph_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            sl_q    <= sl_d;
            isel_q  <= isel_d;
            ds_q    <= ds_d;
            db_q    <= db_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        ph_d    = ph_q;
        tmr_d   = (tmr_q != '0) ? tmr_q - 1'b1 : '0;
        pend_d  = pend_q | (refresh & (st_q != S_IDLE));
        state_d = state_q;
        sl_d    = sl_q;
        isel_d  = isel_q;
        ds_d    = ds_q;
        db_d    = db_q;
        idx_d   = idx_q;
        rs_d    = rs_q;
        last_d  = last_q;
        wr_done = 1'b0;

        // Shared SETUP/EHI/WAIT write primitive for INIT, ADDR and CHAR
        if (st_q == S_INIT || st_q == S_ADDR || st_q == S_CHAR) begin
            case (ph_q)
                P_SETUP: begin
                    ph_d  = P_EHI;
                    tmr_d = CW'(T_EH);
                end
                P_EHI: begin
                    if (tmr_q == CW'(1)) begin
                        ph_d  = P_WAIT;
                        tmr_d = (!db_q && isel_q == 2'd2) ? CW'(T_CLR) : CW'(T_CMD);
                    end
                end
                P_WAIT:  wr_done = (tmr_q == CW'(1));
                default: ph_d = P_SETUP;
            endcase
        end

        case (st_q)
            S_PWR: begin
                // A cleared timer means the wait has not been armed yet
                if (tmr_q == '0) begin
                    tmr_d = CW'(T_PWR);
                end else if (tmr_q == CW'(1)) begin
                    st_d   = S_INIT;
                    ph_d   = P_SETUP;
                    isel_d = 2'd0;
                    db_d   = 1'b0;
                    ds_d   = 1'b0;
                    rs_d   = 1'b0;
                end
            end
            S_INIT: begin
                if (wr_done) begin
                    if (isel_q == 2'd3) begin
                        st_d = S_IDLE;
                    end else begin
                        isel_d = isel_q + 2'd1;
                        ph_d   = P_SETUP;
                    end
                end
            end
            S_IDLE: begin
                if (refresh || pend_q) begin
                    state_d = state;
                    sl_d    = statelocal;
                    last_d  = (state == 2'd1 && statelocal >= 3'd4) ? 2'd1 : 2'd3;
                    pend_d  = 1'b0;
                    st_d    = S_ADDR;
                    ph_d    = P_SETUP;
                    db_d    = 1'b1;
                    ds_d    = 1'b0;
                    rs_d    = 1'b0;
                end
            end
            S_ADDR: begin
                if (wr_done) begin
                    st_d  = S_CHAR;
                    ph_d  = P_SETUP;
                    ds_d  = 1'b1;
                    rs_d  = 1'b1;
                    idx_d = 2'd0;
                end
            end
            S_CHAR: begin
                if (wr_done) begin
                    if (idx_q == last_q) begin
                        st_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        ph_d  = P_SETUP;
                    end
                end
            end
            default: st_d = S_PWR;
        endcase
    end

    assign state_o      = state_q;
    assign statelocal_o = sl_q;
    assign init_sel     = isel_q;
    assign data_sel     = ds_q;
    assign DB_sel       = db_q;
    assign index        = idx_q;
    assign LCD_RS       = rs_q;
    assign LCD_RW       = 1'b0;
    assign LCD_E        = (ph_q == P_EHI);
    assign ready        = (st_q == S_IDLE) && !pend_q;

endmodule
